// File: rtl/sa_run_if.sv
// sa_run_if: control, operand-read and drain signals between the run sequencer and its neighbours.
interface sa_run_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    logic               enable;
    logic               start;
    logic [KW-1:0]      k_len;
    logic               busy;
    logic               pe_clear;
    logic [ROWS-1:0]    a_rd_en;
    logic [ROWS*KW-1:0] a_rd_addr;
    logic [COLS-1:0]    b_rd_en;
    logic [COLS*KW-1:0] b_rd_addr;
    logic               out_valid;
    logic [RW-1:0]      out_row;
    logic               done;
    logic               timeout_err;
    modport master (
        output enable, start, k_len,
        input  busy, pe_clear, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, out_valid, out_row, done, timeout_err
    );
    modport slave (
        input  enable, start, k_len,
        output busy, pe_clear, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, out_valid, out_row, done, timeout_err
    );
endinterface

// File: rtl/sa_run_ctrl.sv
// sa_run_ctrl: start/done run sequencer for an output-stationary systolic array.
// All outputs are registered from the next-state decode, so a pulse appears the cycle its state is entered.
module sa_run_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int KW     = 8,
    parameter int PE_LAT = 1,
    parameter int TO_W   = 16
) (
    input logic     clk_i,
    input logic     rst_ni,
    sa_run_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = KW + $clog2(ROWS + COLS) + 1;
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [TW-1:0]      t_q, t_d, t_end;
    logic [RW-1:0]      row_q, row_d, out_row_q, out_row_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic               terr_q, terr_d, busy_q, busy_d, pe_clear_q, pe_clear_d;
    logic               out_valid_q, out_valid_d, done_q, done_d, run;
    logic [ROWS-1:0]    a_en_q, a_en_d;
    logic [ROWS*KW-1:0] a_addr_q, a_addr_d;
    logic [COLS-1:0]    b_en_q, b_en_d;
    logic [COLS*KW-1:0] b_addr_q, b_addr_d;

    assign t_end = TW'(k_q) + TW'(ROWS + COLS + PE_LAT - 3);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        row_d   = row_q;
        wd_d    = wd_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: if (bus.start && bus.enable) begin
                k_d     = bus.k_len;
                terr_d  = 1'b0;
                wd_d    = TO_W'(1);
                t_d     = '0;
                row_d   = '0;
                state_d = (bus.k_len != '0) ? CLEAR : DONE;
            end
            CLEAR: if (bus.enable) begin
                state_d = RUN;
                t_d     = '0;
            end
            RUN: if (bus.enable) begin
                state_d = (t_q == t_end) ? DRAIN : RUN;
                t_d     = (t_q == t_end) ? t_q : t_q + 1'b1;
                row_d   = '0;
            end
            DRAIN: if (bus.enable) begin
                state_d = (row_q == RW'(ROWS - 1)) ? DONE : DRAIN;
                row_d   = (row_q == RW'(ROWS - 1)) ? row_q : row_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // watchdog keeps counting through stalls and overrides whatever the FSM wanted
        if (state_q inside {CLEAR, RUN, DRAIN}) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_LAST) begin
                state_d = ERR;
                terr_d  = 1'b1;
            end
        end
    end

    always_comb begin
        run         = bus.enable && state_d == RUN;
        busy_d      = state_d != IDLE;
        pe_clear_d  = bus.enable && state_d == CLEAR;
        out_valid_d = bus.enable && state_d == DRAIN;
        out_row_d   = (state_d == DRAIN) ? row_d : '0;
        done_d      = bus.enable && state_d == DONE;
        a_en_d      = '0;
        a_addr_d    = '0;
        b_en_d      = '0;
        b_addr_d    = '0;
        for (int i = 0; i < ROWS; i++) begin
            a_en_d[i]            = run && t_d >= TW'(i) && t_d < TW'(i) + TW'(k_q);
            a_addr_d[i*KW +: KW] = a_en_d[i] ? KW'(t_d - TW'(i)) : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            b_en_d[j]            = run && t_d >= TW'(j) && t_d < TW'(j) + TW'(k_q);
            b_addr_d[j*KW +: KW] = b_en_d[j] ? KW'(t_d - TW'(j)) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            k_q         <= '0;
            t_q         <= '0;
            row_q       <= '0;
            wd_q        <= '0;
            terr_q      <= 1'b0;
            busy_q      <= 1'b0;
            pe_clear_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            done_q      <= 1'b0;
            a_en_q      <= '0;
            a_addr_q    <= '0;
            b_en_q      <= '0;
            b_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            row_q       <= row_d;
            wd_q        <= wd_d;
            terr_q      <= terr_d;
            busy_q      <= busy_d;
            pe_clear_q  <= pe_clear_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            done_q      <= done_d;
            a_en_q      <= a_en_d;
            a_addr_q    <= a_addr_d;
            b_en_q      <= b_en_d;
            b_addr_q    <= b_addr_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.pe_clear    = pe_clear_q;
    assign bus.a_rd_en     = a_en_q;
    assign bus.a_rd_addr   = a_addr_q;
    assign bus.b_rd_en     = b_en_q;
    assign bus.b_rd_addr   = b_addr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_row     = out_row_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_sa_run_ctrl.sv
// tb_sa_run_ctrl: directed scenario bench; cycle c is the c-th cycle after the edge that accepts start.
// Three instances: 4x4 nominal, 4x4 with a 4-bit watchdog, 2x5 for the back-to-back run.
module tb_sa_run_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sa_run_if #(.ROWS(4), .COLS(4), .KW(8)) if0 ();
    sa_run_if #(.ROWS(4), .COLS(4), .KW(8)) if1 ();
    sa_run_if #(.ROWS(2), .COLS(5), .KW(8)) if2 ();

    sa_run_ctrl #(.ROWS(4), .COLS(4), .KW(8), .PE_LAT(1), .TO_W(16)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
    sa_run_ctrl #(.ROWS(4), .COLS(4), .KW(8), .PE_LAT(1), .TO_W(4))  u1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
    sa_run_ctrl #(.ROWS(2), .COLS(5), .KW(8), .PE_LAT(1), .TO_W(16)) u2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

    // {busy, pe_clear, out_valid, out_row, done, timeout_err} and {a_en, a_addr, b_en, b_addr}
    logic [6:0]  a0, a1;
    logic [5:0]  a2;
    logic [71:0] r0, r1;
    logic [62:0] r2;
    assign a0 = {if0.busy, if0.pe_clear, if0.out_valid, if0.out_row, if0.done, if0.timeout_err};
    assign a1 = {if1.busy, if1.pe_clear, if1.out_valid, if1.out_row, if1.done, if1.timeout_err};
    assign a2 = {if2.busy, if2.pe_clear, if2.out_valid, if2.out_row, if2.done, if2.timeout_err};
    assign r0 = {if0.a_rd_en, if0.a_rd_addr, if0.b_rd_en, if0.b_rd_addr};
    assign r1 = {if1.a_rd_en, if1.a_rd_addr, if1.b_rd_en, if1.b_rd_addr};
    assign r2 = {if2.a_rd_en, if2.a_rd_addr, if2.b_rd_en, if2.b_rd_addr};

    // Expected control outputs of an unstalled run: clear 1, RUN 2..te+2, DRAIN rows cycles, done te+rows+3
    function automatic logic [6:0] ctl_exp(input int rows, input int c, input int te);
        logic b, pe, ov, dn;
        logic [1:0] row;
        b   = c >= 1 && c <= te + rows + 3;
        pe  = c == 1;
        ov  = c >= te + 3 && c <= te + rows + 2;
        row = ov ? 2'(c - te - 3) : 2'd0;
        dn  = c == te + rows + 3;
        return {b, pe, ov, row, dn, 1'b0};
    endfunction

    // Expected read strobes: channel i reads address t-i while i <= t <= i+k-1, t = c-2 during RUN
    function automatic void rd_exp(input int n, input int c, input int k, input int te,
                                   output logic [7:0] en, output logic [63:0] ad);
        en = '0;
        ad = '0;
        for (int i = 0; i < n; i++)
            if (c >= 2 && c <= te + 2 && c - 2 >= i && c - 2 <= i + k - 1) begin
                en[i]       = 1'b1;
                ad[i*8 +: 8] = 8'(c - 2 - i);
            end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if0.enable = 0; if0.start = 0; if0.k_len = 0;
        if1.enable = 0; if1.start = 0; if1.k_len = 0;
        if2.enable = 0; if2.start = 0; if2.k_len = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({a0, r0} !== '0) begin n_fail++; $display("FAIL reset_u0 got=%h/%h exp=0", a0, r0); end
        n_tests++;
        if ({a1, r1} !== '0) begin n_fail++; $display("FAIL reset_u1 got=%h/%h exp=0", a1, r1); end
        n_tests++;
        if ({a2, r2} !== '0) begin n_fail++; $display("FAIL reset_u2 got=%h/%h exp=0", a2, r2); end
        rst_n = 1'b1;
        if0.enable = 1; if1.enable = 1; if2.enable = 1;
        step();
        n_tests++;
        if ({a0, r0} !== '0) begin n_fail++; $display("FAIL idle_after_reset got=%h/%h exp=0", a0, r0); end
    endtask

    task automatic test_basic(input string nm);
        logic [7:0] en;
        logic [63:0] ad;
        logic [6:0] ec;
        logic [71:0] er;
        if0.k_len = 8'd4;
        if0.start = 1;
        step();
        if0.start = 0;
        for (int c = 1; c <= 18; c++) begin
            ec = ctl_exp(4, c, 10);
            rd_exp(4, c, 4, 10, en, ad);
            er = {en[3:0], ad[31:0], en[3:0], ad[31:0]};
            n_tests++;
            if ({a0, r0} !== {ec, er}) begin
                n_fail++;
                $display("FAIL %s c=%0d got=%h/%h exp=%h/%h", nm, c, a0, r0, ec, er);
            end
            step();
        end
    endtask

    task automatic test_zero_len();
        logic [6:0] ec;
        if0.k_len = 8'd0;
        if0.start = 1;
        step();
        if0.start = 0;
        for (int c = 1; c <= 4; c++) begin
            ec = (c == 1) ? 7'b1000010 : 7'b0000000;
            n_tests++;
            if ({a0, r0} !== {ec, 72'd0}) begin
                n_fail++;
                $display("FAIL zero_len c=%0d got=%h/%h exp=%h/0", c, a0, r0, ec);
            end
            step();
        end
    endtask

    // enable is low at the edges that launch cycles 6..8
    task automatic test_stall();
        logic [7:0] en;
        logic [63:0] ad;
        logic [6:0] ec;
        logic [71:0] er;
        int cc;
        if0.k_len = 8'd4;
        if0.start = 1;
        step();
        if0.start = 0;
        for (int c = 1; c <= 21; c++) begin
            cc = (c > 8) ? c - 3 : c;
            ec = ctl_exp(4, cc, 10);
            rd_exp(4, cc, 4, 10, en, ad);
            er = {en[3:0], ad[31:0], en[3:0], ad[31:0]};
            if (c >= 6 && c <= 8) begin
                ec = 7'b1000000;
                er = '0;
            end
            n_tests++;
            if ({a0, r0} !== {ec, er}) begin
                n_fail++;
                $display("FAIL stall c=%0d got=%h/%h exp=%h/%h", c, a0, r0, ec, er);
            end
            if0.enable = (c < 5 || c > 7);
            step();
        end
        if0.enable = 1;
    endtask

    task automatic test_watchdog();
        logic [7:0] en;
        logic [63:0] ad;
        logic [6:0] ec;
        logic [71:0] er;
        if1.k_len = 8'd4;
        if1.start = 1;
        step();
        if1.start = 0;
        for (int c = 1; c <= 18; c++) begin
            rd_exp(4, c, 4, 10, en, ad);
            er = (c <= 3) ? {en[3:0], ad[31:0], en[3:0], ad[31:0]} : 72'd0;
            ec = (c <= 3) ? ctl_exp(4, c, 10) : (c < 15) ? 7'b1000000 : (c == 15) ? 7'b1000001 : 7'b0000001;
            n_tests++;
            if ({a1, r1} !== {ec, er}) begin
                n_fail++;
                $display("FAIL watchdog c=%0d got=%h/%h exp=%h/%h", c, a1, r1, ec, er);
            end
            if (c == 3) if1.enable = 0;
            step();
        end
        // a k_len=1 run is 14 busy cycles, short enough to finish under this watchdog
        if1.enable = 1;
        if1.k_len = 8'd1;
        if1.start = 1;
        step();
        if1.start = 0;
        for (int c = 1; c <= 15; c++) begin
            ec = ctl_exp(4, c, 7);
            rd_exp(4, c, 1, 7, en, ad);
            er = {en[3:0], ad[31:0], en[3:0], ad[31:0]};
            n_tests++;
            if ({a1, r1} !== {ec, er}) begin
                n_fail++;
                $display("FAIL watchdog_recover c=%0d got=%h/%h exp=%h/%h", c, a1, r1, ec, er);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_drain();
        if0.k_len = 8'd4;
        if0.start = 1;
        step();
        if0.start = 0;
        for (int c = 1; c < 14; c++) step();
        n_tests++;
        if (a0 !== ctl_exp(4, 14, 10)) begin
            n_fail++;
            $display("FAIL pre_reset_drain got=%h exp=%h", a0, ctl_exp(4, 14, 10));
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a0, r0} !== '0) begin n_fail++; $display("FAIL async_reset got=%h/%h exp=0", a0, r0); end
        @(negedge clk) rst_n = 1'b1;
        step();
        step();
        n_tests++;
        if ({a0, r0} !== '0) begin n_fail++; $display("FAIL no_done_after_reset got=%h/%h exp=0", a0, r0); end
        test_basic("run_after_reset");
    endtask

    // start stays high through the whole run; the re-request is only taken once IDLE is sampled (edge 14)
    task automatic test_back_to_back();
        logic [7:0] ena, enb;
        logic [63:0] ada, adb;
        logic [6:0] e;
        logic [5:0] ec;
        logic [62:0] er;
        int cc;
        if2.k_len = 8'd3;
        if2.start = 1;
        step();
        for (int c = 1; c <= 15; c++) begin
            cc = (c <= 14) ? c : c - 14;
            e  = ctl_exp(2, cc, 8);
            ec = {e[6:4], e[2:0]};
            rd_exp(2, cc, 3, 8, ena, ada);
            rd_exp(5, cc, 3, 8, enb, adb);
            er = {ena[1:0], ada[15:0], enb[4:0], adb[39:0]};
            n_tests++;
            if ({a2, r2} !== {ec, er}) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d got=%h/%h exp=%h/%h", c, a2, r2, ec, er);
            end
            if (c == 15) if2.start = 0;
            step();
        end
        for (int i = 0; i < 30 && if2.busy; i++) step();
        n_tests++;
        if (if2.busy !== 1'b0) begin n_fail++; $display("FAIL second_run_end busy=%b exp=0", if2.busy); end
    endtask

    initial begin
        test_reset();
        test_basic("run1");
        test_zero_len();
        test_stall();
        test_watchdog();
        test_reset_mid_drain();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
